// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage of the 5-stage RISC-V pipeline.
//
// Issues one instruction-memory request at a time for the current pc, computes
// next_pc for the program_counter register (sequential +4, hold, redirect) and
// owns the IF/ID pipeline register with a one-entry skid buffer and flush.
//
// Ports:
//   clk, reset                 rising-edge clock, asynchronous active-high reset
//   pc                         current PC from program_counter
//   next_pc                    combinational next PC, loaded every cycle
//   imem_req/addr/gnt          request handshake; imem_addr always equals pc
//   imem_rvalid/rdata          in-order response, at most one per grant
//   stall                      ID cannot accept a new IF/ID entry
//   redirect/redirect_pc       taken branch/jump from EX, flushes the front end
//   if_id_valid/pc/instr       IF/ID pipeline register
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  output logic [31:0] next_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        if_id_valid,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_instr
);

  typedef enum logic [1:0] {
    StReq,   // free to issue a request
    StWait,  // one request outstanding
    StFull,  // response parked in the skid buffer, waiting for ID
    StDrop   // outstanding response belongs to a flushed path
  } state_e;

  state_e      state_q;
  logic [31:0] req_pc_q;
  logic [31:0] skid_pc_q;
  logic [31:0] skid_instr_q;
  logic        accept;
  logic        grant;

  // IF/ID can take a new entry when empty or when ID consumes it this cycle.
  assign accept    = !if_id_valid || !stall;
  assign imem_addr = pc;
  assign grant     = imem_req && imem_gnt;

  // Request depends on rvalid (back-to-back issue) but never on imem_gnt.
  always_comb begin
    imem_req = 1'b0;
    case (state_q)
      StReq:   imem_req = !redirect;
      StWait:  imem_req = imem_rvalid && accept && !redirect;
      default: imem_req = 1'b0;
    endcase
    if (reset) begin
      imem_req = 1'b0;
    end
  end

  always_comb begin
    next_pc = pc;
    if (redirect) begin
      next_pc = {redirect_pc[31:2], 2'b00};
    end else if (grant) begin
      next_pc = pc + 32'd4;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StReq;
      req_pc_q     <= RESET_PC;
      skid_pc_q    <= RESET_PC;
      skid_instr_q <= NOP_INSTR;
      if_id_valid  <= 1'b0;
      if_id_pc     <= RESET_PC;
      if_id_instr  <= NOP_INSTR;
    end else begin
      if (grant) begin
        req_pc_q <= pc;
      end

      // Flush, or entry consumed with nothing new: empty the slot. A new entry
      // written below in the same cycle takes precedence.
      if (redirect || accept) begin
        if_id_valid <= 1'b0;
        if_id_instr <= NOP_INSTR;
      end

      case (state_q)
        StReq: begin
          if (grant) begin
            state_q <= StWait;
          end
        end
        StWait: begin
          if (imem_rvalid) begin
            if (redirect) begin
              state_q <= StReq;
            end else if (accept) begin
              if_id_valid <= 1'b1;
              if_id_pc    <= req_pc_q;
              if_id_instr <= imem_rdata;
              state_q     <= grant ? StWait : StReq;
            end else begin
              skid_pc_q    <= req_pc_q;
              skid_instr_q <= imem_rdata;
              state_q      <= StFull;
            end
          end else if (redirect) begin
            state_q <= StDrop;
          end
        end
        StFull: begin
          if (redirect) begin
            skid_pc_q    <= RESET_PC;
            skid_instr_q <= NOP_INSTR;
            state_q      <= StReq;
          end else if (!stall) begin
            if_id_valid <= 1'b1;
            if_id_pc    <= skid_pc_q;
            if_id_instr <= skid_instr_q;
            state_q     <= StReq;
          end
        end
        StDrop: begin
          if (imem_rvalid) begin
            state_q <= StReq;
          end
        end
        default: state_q <= StReq;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit. The bench plays program_counter (a pc
// register loaded from next_pc) and a single-outstanding instruction memory with
// random grant and response latency. The reference model is program order: every
// instruction ID consumes must be the next sequential PC since reset or the last
// redirect, carrying that address's memory word, with nothing lost or repeated.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic [31:0] next_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        if_id_valid;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;

  always #5 clk = ~clk;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pc <= RESET_PC;
    else       pc <= next_pc;
  end

  fetch_unit #(
    .RESET_PC  (RESET_PC),
    .NOP_INSTR (NOP)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .pc          (pc),
    .next_pc     (next_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .if_id_valid (if_id_valid),
    .if_id_pc    (if_id_pc),
    .if_id_instr (if_id_instr)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Memory / program-order model state.
  logic        pend = 1'b0;
  logic [31:0] pend_addr = '0;
  int          pend_lat = 0;
  int          lat_cfg = 0;   // negative: random latency 0..3
  logic [31:0] exp_pc = RESET_PC;
  int          since_prog = 0;
  int          delivered = 0;
  logic        prev_redir = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  // One clock cycle: drive inputs after the rising edge, check on the falling edge.
  task automatic step(input logic st, input logic rd, input logic [31:0] rpc, input logic g);
    logic [31:0] exp_next;
    @(posedge clk);
    #1;
    stall       = st;
    redirect    = rd;
    redirect_pc = rpc;
    imem_gnt    = g;
    if (pend && pend_lat == 0) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(pend_addr);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
      if (pend) pend_lat--;
    end
    @(negedge clk);

    check_eq("imem_addr", imem_addr, pc);
    if (rd)                     exp_next = {rpc[31:2], 2'b00};
    else if (imem_req && g)     exp_next = pc + 32'd4;
    else                        exp_next = pc;
    check_eq("next_pc", next_pc, exp_next);
    if (rd) check_eq("req_on_redirect", {31'd0, imem_req}, 32'd0);
    if (pend && !imem_rvalid) check_eq("one_outstanding", {31'd0, imem_req}, 32'd0);
    if (prev_redir) check_eq("flush_valid", {31'd0, if_id_valid}, 32'd0);
    if (!if_id_valid) check_eq("nop_when_invalid", if_id_instr, NOP);

    if (rd) begin
      exp_pc     = {rpc[31:2], 2'b00};
      since_prog = 0;
    end else if (if_id_valid && !st) begin
      check_eq("consume_pc", if_id_pc, exp_pc);
      check_eq("consume_instr", if_id_instr, mem_word(exp_pc));
      exp_pc     = exp_pc + 32'd4;
      delivered++;
      since_prog = 0;
    end else begin
      since_prog++;
    end
    if (since_prog > 80) begin
      check_eq("cycles_without_progress", since_prog, 32'd0);
      since_prog = 0;
    end
    prev_redir = rd;

    if (imem_rvalid) pend = 1'b0;
    if (imem_req && g) begin
      pend      = 1'b1;
      pend_addr = pc;
      pend_lat  = (lat_cfg < 0) ? int'($urandom_range(0, 3)) : lat_cfg;
    end
  endtask

  // Asserts reset away from a clock edge and checks outputs before any edge.
  task automatic do_reset(input logic keep_pend);
    reset       = 1'b1;
    stall       = 1'b0;
    redirect    = 1'b0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    #1;
    check_eq("rst_valid", {31'd0, if_id_valid}, 32'd0);
    check_eq("rst_pc", if_id_pc, RESET_PC);
    check_eq("rst_instr", if_id_instr, NOP);
    check_eq("rst_req", {31'd0, imem_req}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_req_held", {31'd0, imem_req}, 32'd0);
    reset = 1'b0;
    if (keep_pend) pend_lat = 0;  // stale response lands in the first cycle
    else           pend = 1'b0;
    exp_pc     = RESET_PC;
    since_prog = 0;
    prev_redir = 1'b0;
  endtask

  initial begin
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;

    // Sequential fetch, then 3-cycle stall with 0x8 in IF/ID and 0xC in flight.
    do_reset(1'b0);
    lat_cfg = 0;
    for (int c = 0; c < 12; c++) begin
      step((c >= 4 && c <= 6), 1'b0, 32'd0, 1'b1);
      if (c < 2) check_eq("seq_latency", {31'd0, if_id_valid}, 32'd0);
      if (c >= 2 && c <= 4) begin
        check_eq("seq_valid", {31'd0, if_id_valid}, 32'd1);
        check_eq("seq_pc", if_id_pc, (c - 2) * 4);
      end
      if (c >= 4 && c <= 6) begin
        check_eq("skid_no_req", {31'd0, imem_req}, 32'd0);
        check_eq("skid_pc_hold", pc, 32'h10);
      end
      if (c == 8) check_eq("skid_release", if_id_pc, 32'hC);
    end

    // Redirect under stall in FULL, then redirect to the top of memory with a
    // grant held off for three cycles so the PC wraps.
    do_reset(1'b0);
    lat_cfg = 0;
    for (int c = 0; c < 19; c++) begin
      step((c == 4 || c == 5), (c == 5 || c == 9),
           (c == 5) ? 32'h40 : 32'hFFFF_FFFF, !(c >= 10 && c <= 12));
      if (c == 6) begin
        check_eq("full_flush_valid", {31'd0, if_id_valid}, 32'd0);
        check_eq("full_flush_pc", pc, 32'h40);
      end
      if (c == 8) check_eq("target_entry", if_id_pc, 32'h40);
      if (c >= 10 && c <= 12) check_eq("wrap_hold", next_pc, 32'hFFFF_FFFC);
      if (c == 13) check_eq("wrap_to_zero", next_pc, 32'h0);
    end

    // Redirect while a request is outstanding; response arrives two cycles later.
    do_reset(1'b0);
    for (int c = 0; c < 9; c++) begin
      lat_cfg = (c == 0) ? 2 : 0;
      step(1'b0, (c == 1), 32'h103, 1'b1);
      if (c == 1) check_eq("redir_target", next_pc, 32'h100);
      if (c == 2 || c == 3) begin
        check_eq("drop_no_req", {31'd0, imem_req}, 32'd0);
        check_eq("drop_valid", {31'd0, if_id_valid}, 32'd0);
      end
      if (c == 4) begin
        check_eq("refetch_addr", imem_addr, 32'h100);
        check_eq("refetch_req", {31'd0, imem_req}, 32'd1);
      end
    end

    // Randomized traffic.
    lat_cfg   = -1;
    delivered = 0;
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) < 30), ($urandom_range(0, 99) < 4), $urandom,
           ($urandom_range(0, 99) < 65));
    end
    check_eq("random_delivered", {31'd0, (delivered > 200)}, 32'd1);

    // Asynchronous reset in the middle of WAIT, followed by a stale response.
    do_reset(1'b0);
    for (int c = 0; c < 5; c++) begin
      lat_cfg = (c == 3) ? 3 : 0;
      step(1'b0, 1'b0, 32'd0, 1'b1);
    end
    check_eq("pre_reset_valid", {31'd0, if_id_valid}, 32'd1);
    check_eq("pre_reset_pc", if_id_pc, 32'h8);
    #2;
    do_reset(1'b1);
    lat_cfg = 0;
    for (int c = 0; c < 12; c++) begin
      step(1'b0, 1'b0, 32'd0, 1'b1);
      if (c == 0) check_eq("stale_ignored", {31'd0, if_id_valid}, 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the 5-stage RISC-V pipeline, directly downstream of `program_counter`. It consumes the current `pc`, issues instruction-memory requests, and computes `next_pc` for the PC register, covering sequential +4, hold on stall, and branch/jump redirect. It also owns the IF/ID pipeline register, including a one-entry skid buffer and flush handling.

## Interface
- `RESET_PC`, default 32'h0000_0000: reset PC. Must match `program_counter` reset value.
- `NOP_INSTR`, default 32'h0000_0013: `addi x0,x0,0`, driven on `if_id_instr` when the slot is invalid.

- `clk`  in  1  clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `pc`  in  32  current PC from `program_counter`.
- `next_pc`  out  32  combinational; `program_counter` loads it every cycle.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  32  equals `pc`.
- `imem_gnt`  in  1  request accepted this cycle; only meaningful while `imem_req`=1.
- `imem_rvalid`  in  1  response valid. At most one response per accepted request, in order, at least 1 cycle after grant.
- `imem_rdata`  in  32  instruction word.
- `stall`  in  1  ID stage cannot accept a new IF/ID entry.
- `redirect`  in  1  taken branch/jump from EX (flush).
- `redirect_pc`  in  32  redirect target.
- `if_id_valid`  out  1  IF/ID entry valid.
- `if_id_pc`  out  32  PC of the IF/ID instruction.
- `if_id_instr`  out  32  IF/ID instruction.

## Operation
- At most one outstanding memory request. `req_pc` latches `pc` on grant and tags the response.
- `accept` = `!if_id_valid || !stall`.
- `next_pc` priority:
  - `redirect`: `{redirect_pc[31:2],2'b00}`.
  - else if `imem_req && imem_gnt`: `pc + 4`, mod 2^32, so 32'hFFFF_FFFC wraps to 0.
  - else: `pc`.
- FSM states:
  - REQ:
    - `imem_req = !redirect`.
    - On grant, go to WAIT.
  - WAIT (request outstanding):
    - `rvalid && redirect`: drop the data, go to REQ.
    - `rvalid && accept`: write IF/ID with `{1, req_pc, rdata}`. Also assert `imem_req = 1` this cycle (back-to-back issue). On grant stay in WAIT; without grant go to REQ.
    - `rvalid && !accept`: write the skid buffer, go to FULL.
    - `!rvalid && redirect`: go to DROP.
  - FULL:
    - `imem_req = 0`.
    - `redirect`: clear the skid, go to REQ.
    - `!stall`: move the skid into IF/ID, go to REQ.
  - DROP:
    - `imem_req = 0`.
    - On `rvalid`, discard the data and go to REQ.
    - A further `redirect` while in DROP stays in DROP and updates `next_pc`.
- IF/ID register:
  - `redirect` forces `if_id_valid <= 0` and `if_id_instr <= NOP_INSTR`, regardless of `stall`.
  - `stall && if_id_valid`: hold all fields.
  - Consumed with no new entry: `if_id_valid <= 0`, `if_id_instr <= NOP_INSTR`.
- `redirect` overrides `stall` in every state.

## Timing
- Reset, asynchronous:
  - State REQ.
  - `if_id_valid` = 0, `if_id_pc` = `RESET_PC`, `if_id_instr` = `NOP_INSTR`.
  - Skid cleared.
  - `imem_req` = 0 while `reset` is high.
- Reset mid-operation abandons any outstanding request. A `rvalid` in the first cycle after reset is ignored (state REQ).
- `next_pc`, `imem_req` and `imem_addr` are combinational. The `rvalid` → `imem_req` path is allowed; there is no comb path from `imem_gnt` to `imem_req`.
- Latency: with grant in cycle N and `rvalid` in N+1, `if_id_valid` is high in N+2.
- Throughput: 1 instruction/cycle with single-cycle memory and no stall.
- Redirect in cycle N: `pc` = target in N+1. The first target instruction is valid in IF/ID no earlier than N+3.

## Test plan
- Sequential fetch: reset, `RESET_PC`=0, memory always grants, `rvalid` 1 cycle later → IF/ID PCs 0, 4, 8, 12 on consecutive cycles starting 2 cycles after the first request.
- Stall with backpressure: assert `stall` for 3 cycles while the instruction at 0x8 is in IF/ID and 0xC is in flight → 0xC lands in the skid, `imem_req`=0 and `pc` holds 0x10. After release, IF/ID sequence is 0x8, 0xC, then 0x10. No instruction is lost or duplicated.
- Redirect while outstanding: `redirect`=1 with `redirect_pc`=0x103 and `rvalid` 2 cycles later → response dropped (state DROP), `if_id_valid`=0, next fetch address 0x100.
- Redirect under stall in FULL: stall plus redirect to 0x40 → `if_id_valid`=0 and skid cleared on the next edge; the next IF/ID entry is PC 0x40.
- Wrap-around and slow memory: `pc`=32'hFFFF_FFFC, grant delayed 3 cycles → `next_pc` holds 0xFFFF_FFFC until grant, then goes to 0x0.
- Asynchronous reset asserted mid-WAIT: outputs return to their reset values immediately, with no clock edge required. A stale `rvalid` after reset never reaches IF/ID.
